// File: rtl/vend_dispenser.sv
// Vending dispenser back-end: 4-deep sale queue, motor/drop/change-eject sequencer.
// Optional drop watchdog with refund path is enabled by defining DISPENSE_TIMEOUT_EN.
module vend_dispenser #(
    parameter int MOTOR_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sell,
    input  logic [1:0] change,
    input  logic       drop_ok,
    output logic       motor_on,
    output logic       coin_eject,
    output logic       busy,
    output logic [7:0] sale_cnt,
    output logic       ovf,
    output logic       err
);

    if (MOTOR_CYCLES < 1 || MOTOR_CYCLES > 15) begin : g_bad_motor
        $error("MOTOR_CYCLES out of range 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..255");
    end

`ifdef DISPENSE_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, MOTOR, WAIT_DROP, EJECT, REFUND} state_t;
`else
    typedef enum logic [2:0] {IDLE, MOTOR, WAIT_DROP, EJECT} state_t;
`endif

    state_t      state_q, state_d;
    logic [1:0]  fifo_q [4];
    logic [1:0]  wr_q, rd_q;
    logic [2:0]  cnt_q;
    logic [1:0]  job_q, job_d;
    logic [3:0]  mtmr_q, mtmr_d;
    logic [2:0]  ej_q, ej_d;
    logic        coin_q, coin_d;
    logic        motor_q, motor_d;
    logic [7:0]  sale_q, sale_d;
    logic        ovf_q, ovf_d;
    logic        empty, full, pop, push, lost;
`ifdef DISPENSE_TIMEOUT_EN
    logic [7:0]  wtmr_q, wtmr_d;
    logic        err_q, err_d;
`endif

    assign empty = (cnt_q == 3'd0);
    assign full  = (cnt_q == 3'd4);
    assign pop   = (state_q == IDLE) && !empty;
    // A full queue still takes the new sale when the head leaves on the same edge.
    assign push  = sell && (!full || pop);
    assign lost  = sell && full && !pop;

    always_comb begin
        state_d = state_q;
        job_d   = job_q;
        mtmr_d  = mtmr_q;
        ej_d    = ej_q;
        coin_d  = 1'b0;
        sale_d  = sale_q;
        ovf_d   = ovf_q | lost;
`ifdef DISPENSE_TIMEOUT_EN
        wtmr_d  = wtmr_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pop) begin
                    job_d   = fifo_q[rd_q];
                    mtmr_d  = 4'(MOTOR_CYCLES - 1);
                    state_d = MOTOR;
                end
            end
            MOTOR: begin
                if (mtmr_q == 4'd0) begin
                    state_d = WAIT_DROP;
`ifdef DISPENSE_TIMEOUT_EN
                    wtmr_d  = 8'd0;
`endif
                end else begin
                    mtmr_d = mtmr_q - 4'd1;
                end
            end
            WAIT_DROP: begin
                if (drop_ok) begin
                    sale_d = (sale_q == 8'hFF) ? sale_q : sale_q + 8'd1;
                    if (job_q != 2'd0) begin
                        state_d = EJECT;
                        coin_d  = 1'b1;
                        ej_d    = {1'b0, job_q} - 3'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
`ifdef DISPENSE_TIMEOUT_EN
                else if (wtmr_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    // Refund is price (3 coins) plus owed change; first pulse starts now.
                    err_d   = 1'b1;
                    state_d = REFUND;
                    coin_d  = 1'b1;
                    ej_d    = {1'b0, job_q} + 3'd2;
                end else begin
                    wtmr_d = wtmr_q + 8'd1;
                end
`endif
            end
            default: begin
                // EJECT / REFUND: ej_q counts pulses still to issue after the current one.
                if (coin_q) begin
                    coin_d = 1'b0;
                end else if (ej_q == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    coin_d = 1'b1;
                    ej_d   = ej_q - 3'd1;
                end
            end
        endcase
        motor_d = (state_d == MOTOR);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            for (int i = 0; i < 4; i++) fifo_q[i] <= 2'd0;
            wr_q    <= 2'd0;
            rd_q    <= 2'd0;
            cnt_q   <= 3'd0;
            job_q   <= 2'd0;
            mtmr_q  <= 4'd0;
            ej_q    <= 3'd0;
            coin_q  <= 1'b0;
            motor_q <= 1'b0;
            sale_q  <= 8'd0;
            ovf_q   <= 1'b0;
`ifdef DISPENSE_TIMEOUT_EN
            wtmr_q  <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (push) begin
                fifo_q[wr_q] <= change;
                wr_q         <= wr_q + 2'd1;
            end
            if (pop) rd_q <= rd_q + 2'd1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
            job_q   <= job_d;
            mtmr_q  <= mtmr_d;
            ej_q    <= ej_d;
            coin_q  <= coin_d;
            motor_q <= motor_d;
            sale_q  <= sale_d;
            ovf_q   <= ovf_d;
`ifdef DISPENSE_TIMEOUT_EN
            wtmr_q  <= wtmr_d;
            err_q   <= err_d;
`endif
        end
    end

    assign motor_on   = motor_q;
    assign coin_eject = coin_q;
    assign busy       = (state_q != IDLE) || !empty;
    assign sale_cnt   = sale_q;
    assign ovf        = ovf_q;
`ifdef DISPENSE_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_vend_dispenser.sv
// Scoreboard bench for vend_dispenser: expected motor lengths and coin bursts are queued
// at stimulus time and popped by an independent output monitor.
module tb_vend_dispenser;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sell = 1'b0;
    logic [1:0] change = 2'd0;
    logic       drop_ok = 1'b0;
    logic       motor_on, coin_eject, busy, ovf, err;
    logic [7:0] sale_cnt;

    int checks = 0;
    int errors = 0;
    int mq[$];
    int cq[$];

    vend_dispenser #(.MOTOR_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rstn(rstn), .sell(sell), .change(change), .drop_ok(drop_ok),
        .motor_on(motor_on), .coin_eject(coin_eject), .busy(busy),
        .sale_cnt(sale_cnt), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        sell = 1'b0;
        drop_ok = 1'b0;
        mq.delete();
        cq.delete();
        repeat (2) tick;
        rstn = 1'b1;
    endtask

    task automatic expect_sale(input int ch);
        mq.push_back(4);
        if (ch != 0) cq.push_back(ch);
    endtask

    task automatic sell_one(input logic [1:0] ch);
        sell = 1'b1;
        change = ch;
        tick;
        sell = 1'b0;
        change = 2'd0;
    endtask

    task automatic wait_motor(input logic lvl, input string name);
        int n = 0;
        while (motor_on !== lvl && n < 40) begin
            tick;
            n++;
        end
        if (motor_on !== lvl) chk(name, int'(motor_on), int'(lvl));
    endtask

    task automatic serve;
        wait_motor(1'b1, "wait_motor_on");
        wait_motor(1'b0, "wait_motor_off");
        drop_ok = 1'b1;
        tick;
        drop_ok = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            tick;
            n++;
        end
        if (busy) chk("wait_idle_timeout", int'(busy), 0);
    endtask

    // Output monitor
    int mlen = 0, clen = 0, gap = 0;
    logic prev_coin = 1'b0;
    always @(negedge clk) begin
        if (!rstn) begin
            mlen = 0;
            clen = 0;
            gap = 0;
            prev_coin = 1'b0;
        end else begin
            if (motor_on) begin
                mlen++;
            end else if (mlen != 0) begin
                if (mq.size() == 0) chk("motor_unexpected", mlen, 0);
                else chk("motor_len", mlen, mq.pop_front());
                mlen = 0;
            end
            if (coin_eject) begin
                chk("coin_width", int'(prev_coin), 0);
                clen++;
                gap = 0;
            end else if (clen != 0) begin
                gap++;
                if (gap == 2) begin
                    if (cq.size() == 0) chk("coin_unexpected", clen, 0);
                    else chk("coin_burst", clen, cq.pop_front());
                    clen = 0;
                    gap = 0;
                end
            end
            prev_coin = coin_eject;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        int chs[6] = '{1, 2, 3, 1, 2, 3};
        int act;

        // Basic sale, no change
        do_reset;
        chk("rst_motor", int'(motor_on), 0);
        chk("rst_coin", int'(coin_eject), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sale_cnt", int'(sale_cnt), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_err", int'(err), 0);
        expect_sale(0);
        sell_one(2'd0);
        chk("t1_busy_E0", int'(busy), 1);
        chk("t1_motor_E0", int'(motor_on), 0);
        tick;
        chk("t1_motor_E1", int'(motor_on), 1);
        repeat (3) tick;
        chk("t1_motor_E4", int'(motor_on), 1);
        tick;
        chk("t1_motor_E5", int'(motor_on), 0);
        tick;
        drop_ok = 1'b1;
        tick;
        drop_ok = 1'b0;
        chk("t1_sale_cnt", int'(sale_cnt), 1);
        chk("t1_busy_done", int'(busy), 0);
        chk("t1_coin", int'(coin_eject), 0);
        drop_ok = 1'b1;
        repeat (5) tick;
        drop_ok = 1'b0;
        chk("t1_drop_in_idle", int'(sale_cnt), 1);

        // Change of two coins; drop held through MOTOR must be ignored until WAIT_DROP
        do_reset;
        expect_sale(2);
        sell_one(2'd2);
        drop_ok = 1'b1;
        repeat (5) tick;
        chk("t2_drop_in_motor", int'(sale_cnt), 0);
        tick;
        drop_ok = 1'b0;
        chk("t2_sale_cnt", int'(sale_cnt), 1);
        chk("t2_coin_first", int'(coin_eject), 1);
        repeat (4) tick;
        chk("t2_busy_done", int'(busy), 0);
        repeat (3) tick;
        chk("t2_sb_drained", mq.size() + cq.size(), 0);

        // Overflow and FIFO ordering
        do_reset;
        for (int i = 0; i < 6; i++) begin
            if (i < 5) expect_sale(chs[i]);
            sell = 1'b1;
            change = 2'(chs[i]);
            tick;
            if (i == 4) chk("t3_ovf_before", int'(ovf), 0);
            if (i == 5) chk("t3_ovf_set", int'(ovf), 1);
        end
        sell = 1'b0;
        change = 2'd0;
        chk("t3_motor_off_E5", int'(motor_on), 0);
        drop_ok = 1'b1;
        tick;
        drop_ok = 1'b0;
        repeat (4) serve;
        wait_idle(60);
        repeat (3) tick;
        chk("t3_sale_cnt", int'(sale_cnt), 5);
        chk("t3_ovf_sticky", int'(ovf), 1);
        chk("t3_sb_drained", mq.size() + cq.size(), 0);

        // Asynchronous reset during MOTOR with two jobs queued
        sell_one(2'd0);
        sell_one(2'd2);
        sell_one(2'd1);
        chk("t5_motor_before", int'(motor_on), 1);
        #2 rstn = 1'b0;
        #1;
        chk("t5_motor_async", int'(motor_on), 0);
        chk("t5_busy_async", int'(busy), 0);
        chk("t5_sale_cnt_async", int'(sale_cnt), 0);
        chk("t5_ovf_async", int'(ovf), 0);
        mq.delete();
        cq.delete();
        repeat (2) tick;
        rstn = 1'b1;
        act = 0;
        drop_ok = 1'b1;
        repeat (30) begin
            tick;
            if (motor_on || coin_eject || busy) act++;
        end
        drop_ok = 1'b0;
        chk("t5_no_activity", act, 0);
        chk("t5_sale_cnt", int'(sale_cnt), 0);

        // Drop watchdog
        do_reset;
        mq.push_back(4);
`ifdef DISPENSE_TIMEOUT_EN
        cq.push_back(4);
`endif
        sell_one(2'd1);
        repeat (5) tick;
        chk("t4_motor_off", int'(motor_on), 0);
`ifdef DISPENSE_TIMEOUT_EN
        repeat (15) tick;
        chk("t4_err_before", int'(err), 0);
        tick;
        chk("t4_err_set", int'(err), 1);
        chk("t4_refund_first", int'(coin_eject), 1);
        wait_idle(40);
        repeat (3) tick;
        chk("t4_sale_cnt", int'(sale_cnt), 0);
        chk("t4_sb_drained", mq.size() + cq.size(), 0);
`else
        repeat (100) tick;
        chk("t4_still_busy", int'(busy), 1);
        chk("t4_err", int'(err), 0);
        chk("t4_coin", int'(coin_eject), 0);
        chk("t4_sale_cnt", int'(sale_cnt), 0);
        chk("t4_sb_drained", mq.size() + cq.size(), 0);
`endif

        // Counter saturation
        do_reset;
        for (int i = 0; i < 256; i++) begin
            expect_sale(0);
            sell_one(2'd0);
            serve;
            if (i == 254) chk("t6_sale_cnt_255", int'(sale_cnt), 255);
        end
        chk("t6_sale_cnt_sat", int'(sale_cnt), 255);
        drop_ok = 1'b1;
        repeat (5) tick;
        drop_ok = 1'b0;
        chk("t6_drop_idle_sat", int'(sale_cnt), 255);
        chk("t6_sb_drained", mq.size() + cq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vend_dispenser.md
VEND_DISPENSER -- requirements
Module: vend_dispenser

Interface
REQ-001 Parameter MOTOR_CYCLES, default 4, number of cycles motor_on stays high per sale (legal 1..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 16, drop-sensor watchdog limit in cycles (legal 1..255).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 sell  input  1  one-cycle sale pulse from the upstream vending FSM.
REQ-006 change  input  2  change owed with this sale, in half-unit coins (00 none, 01 one, 10 two, 11 three); qualified by sell only.
REQ-007 drop_ok  input  1  product-drop sensor, active-high, sampled on clk.
REQ-008 motor_on  output  1  dispense motor drive, registered.
REQ-009 coin_eject  output  1  change ejector, one high cycle per half-unit coin, registered.
REQ-010 busy  output  1  high while any sale is queued or in progress.
REQ-011 sale_cnt  output  8  completed-sale counter.
REQ-012 ovf  output  1  sticky, set when a sale is lost to a full queue.
REQ-013 err  output  1  sticky, set on drop timeout (see Configuration).

Function
REQ-014 Sale queue: 4-entry FIFO of 2-bit change values; the edge sampling sell=1 writes change when not full.
REQ-015 sell=1 while FIFO full: entry discarded, ovf set at that edge, queue contents unchanged.
REQ-016 Push and pop in the same cycle both take effect; a full FIFO with simultaneous pop still accepts the push.
REQ-017 FSM states: IDLE, MOTOR, WAIT_DROP, EJECT, and REFUND (present only with the macro).
REQ-018 IDLE: FIFO non-empty at an edge -> pop head into job register, go to MOTOR; a sale arriving into an empty idle block is popped on the edge after the write.
REQ-019 MOTOR: motor_on=1 for exactly MOTOR_CYCLES cycles, then go to WAIT_DROP with motor_on=0.
REQ-020 WAIT_DROP: drop_ok=1 -> sale_cnt increments, saturating at 255; go to EJECT if job change!=0, else IDLE.
REQ-021 drop_ok is ignored in every state other than WAIT_DROP.
REQ-022 EJECT: emit N pulses (N = job change), each 1 cycle high then 1 cycle low; return to IDLE after the final low cycle.
REQ-023 busy = (state != IDLE) OR FIFO non-empty.
REQ-024 Queued sales are processed strictly in arrival order; new sells are accepted in every state.

Reset
REQ-025 rstn low forces immediately: state IDLE, FIFO empty, motor_on=0, coin_eject=0, busy=0, sale_cnt=0, ovf=0, err=0, all timers 0.
REQ-026 Reset mid-operation abandons the current job and all queued jobs; no pulse or count is completed.
REQ-027 Reset release is synchronous to the design: the first state update occurs on the first rising edge with rstn high.

Configuration
REQ-028 Macro DISPENSE_TIMEOUT_EN defined: WAIT_DROP counts cycles; after TIMEOUT_CYCLES cycles without drop_ok -> set err, go to REFUND.
REQ-029 REFUND: eject (job change + 3) half-unit pulses (price refund plus change, 3-bit count, max 6) in REQ-022 format, then IDLE; sale_cnt unchanged.
REQ-030 Macro not defined: no watchdog, WAIT_DROP waits indefinitely, REFUND absent, err constant 0.

Verification (MOTOR_CYCLES=4, TIMEOUT_CYCLES=16)
REQ-031 Reset, then sell=1/change=00 at edge E0, drop_ok pulse 2 cycles after motor stops -> motor_on high from E1 for 4 cycles, sale_cnt=1, no coin_eject, busy low afterwards.
REQ-032 Sale with change=10 and prompt drop_ok -> exactly 2 coin_eject pulses separated by one low cycle, sale_cnt=1.
REQ-033 6 back-to-back sells with no drop_ok -> 1 popped plus 4 queued, 6th sale lost, ovf=1; then 5 drop_ok events -> sale_cnt=5, sales served in FIFO order.
REQ-034 With DISPENSE_TIMEOUT_EN: sale change=01, drop_ok held low -> err=1 after 16 WAIT_DROP cycles, 4 coin_eject pulses, sale_cnt=0; without the macro: still in WAIT_DROP after 100 cycles, err=0.
REQ-035 rstn pulsed low during MOTOR with 2 jobs queued -> motor_on drops asynchronously, busy=0, sale_cnt and ovf cleared, no further activity.
REQ-036 256 completed sales -> sale_cnt holds at 255; drop_ok outside WAIT_DROP does not change sale_cnt.
